// File: rtl/sda_axil_reg_bridge_pkg.sv
// Shared types for the AXI4-Lite to register-bus bridge.
// Holds the FSM state encoding and the AXI response codes.
package sda_reg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        WR_RESP,
        RD_RESP
    } bridgeState_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sda_axil_reg_bridge_timer.sv
// Loadable down-counter that flags expiry when it reaches zero.
// Used by the bridge to bound how long regReq waits for regAck.
module sda_reg_timeout_timer #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [Width-1:0] loadValue,
    output logic             expired
);

    logic [Width-1:0] count;

    always_ff @(posedge clk) begin
        if (srst || load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sda_axil_reg_bridge.sv
// AXI4-Lite slave to simple register bus master, round-robin read/write.
// Define SDA_REG_BRIDGE_TIMEOUT_EN to answer SLVERR when regAck never comes.
module sda_axil_reg_bridge
    import sda_reg_bridge_pkg::*;
#(
    parameter int AxiAddrWidth  = 16,
    parameter int RegAddrWidth  = 8,
    parameter int TimeoutCycles = 256
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [AxiAddrWidth-1:0] s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [AxiAddrWidth-1:0] s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    regReq,
    input  logic                    regAck,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic [31:0]             regRData
);

    bridgeState_t state, stateNext;

    logic awHeld, wHeld, arHeld;
    logic [RegAddrWidth-1:2] awAddr, arAddr;
    logic [31:0] wData;
    logic [3:0] wStrb;
    logic lastTieRead;
    logic wrElig, rdElig, timeout;
    logic unusedBits;

    assign wrElig = awHeld & wHeld;
    assign rdElig = arHeld;
    assign s_awready = ~awHeld;
    assign s_wready = ~wHeld;
    assign s_arready = ~arHeld;
    // Byte-lane bits and anything above the register window are dropped.
    assign unusedBits = ^{s_awaddr, s_araddr};

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    logic inReq, timerExpired;

    assign inReq = (state == WR_REQ) || (state == RD_REQ);

    sda_reg_timeout_timer #(
        .Width(16)
    ) u_timer (
        .clk      (clk),
        .srst     (srst),
        .load     (~inReq),
        .loadValue(16'(TimeoutCycles - 1)),
        .expired  (timerExpired)
    );

    assign timeout = inReq & timerExpired;
`else
    localparam int unusedTimeout = TimeoutCycles;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (wrElig && rdElig) begin
                    stateNext = lastTieRead ? WR_REQ : RD_REQ;
                end else if (wrElig) begin
                    stateNext = WR_REQ;
                end else if (rdElig) begin
                    stateNext = RD_REQ;
                end
            end
            WR_REQ:  if (regAck || timeout) stateNext = WR_RESP;
            RD_REQ:  if (regAck || timeout) stateNext = RD_RESP;
            WR_RESP: if (s_bready) stateNext = IDLE;
            RD_RESP: if (s_rready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        regReq = 1'b0;
        regWriteEn = 1'b0;
        regAddr = '0;
        regWData = '0;
        regWStrb = '0;
        s_bvalid = 1'b0;
        s_rvalid = 1'b0;
        unique case (state)
            WR_REQ: begin
                regReq = 1'b1;
                regWriteEn = 1'b1;
                regAddr = {awAddr, 2'b00};
                regWData = wData;
                regWStrb = wStrb;
            end
            RD_REQ: begin
                regReq = 1'b1;
                regAddr = {arAddr, 2'b00};
            end
            WR_RESP: s_bvalid = 1'b1;
            RD_RESP: s_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            awHeld <= 1'b0;
            wHeld <= 1'b0;
            arHeld <= 1'b0;
            awAddr <= '0;
            arAddr <= '0;
            wData <= '0;
            wStrb <= '0;
            lastTieRead <= 1'b0;
            s_bresp <= RESP_OKAY;
            s_rresp <= RESP_OKAY;
            s_rdata <= '0;
        end else begin
            if (s_awvalid && !awHeld) begin
                awHeld <= 1'b1;
                awAddr <= s_awaddr[RegAddrWidth-1:2];
            end
            if (s_wvalid && !wHeld) begin
                wHeld <= 1'b1;
                wData <= s_wdata;
                wStrb <= s_wstrb;
            end
            if (s_arvalid && !arHeld) begin
                arHeld <= 1'b1;
                arAddr <= s_araddr[RegAddrWidth-1:2];
            end
            if (state == WR_RESP && s_bready) begin
                awHeld <= 1'b0;
                wHeld <= 1'b0;
            end
            if (state == RD_RESP && s_rready) begin
                arHeld <= 1'b0;
            end
            // Pointer only moves when both kinds actually competed.
            if (state == IDLE && wrElig && rdElig) begin
                lastTieRead <= ~lastTieRead;
            end
            if (state == WR_REQ) begin
                if (regAck) begin
                    s_bresp <= RESP_OKAY;
                end else if (timeout) begin
                    s_bresp <= RESP_SLVERR;
                end
            end
            if (state == RD_REQ) begin
                if (regAck) begin
                    s_rresp <= RESP_OKAY;
                    s_rdata <= regRData;
                end else if (timeout) begin
                    s_rresp <= RESP_SLVERR;
                    s_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sda_axil_reg_bridge.sv
// Directed bench for sda_axil_reg_bridge with a transaction-level model.
// Timeout scenario runs when SDA_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_sda_axil_reg_bridge;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    logic s_awvalid = 0, s_awready;
    logic [15:0] s_awaddr = '0;
    logic s_wvalid = 0, s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0] s_wstrb = '0;
    logic s_bvalid, s_bready = 1;
    logic [1:0] s_bresp;
    logic s_arvalid = 0, s_arready;
    logic [15:0] s_araddr = '0;
    logic s_rvalid, s_rready = 1;
    logic [31:0] s_rdata;
    logic [1:0] s_rresp;
    logic regReq, regAck = 0, regWriteEn;
    logic [7:0] regAddr;
    logic [31:0] regWData, regRData = '0;
    logic [3:0] regWStrb;

    sda_axil_reg_bridge #(
        .AxiAddrWidth(16),
        .RegAddrWidth(8),
        .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .srst(srst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp),
        .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn),
        .regAddr(regAddr), .regWData(regWData), .regWStrb(regWStrb),
        .regRData(regRData)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } resp_t;

    // Model state: occupied slots, captured requests, expected responses.
    bit awPend, wPend, arPend, prevEligW, prevEligR;
    bit tieRead = 1;
    logic [15:0] mAwAddr, mArAddr;
    logic [31:0] mWData;
    logic [3:0] mWStrb;
    bit inTxn, curWrite, ackGiven, timedOut;
    int reqCycles, reqLen, reqRiseCyc, lowRun, lastGap;
    resp_t expB[$];
    resp_t expR[$];
    bit served[$];
    int ackDelay = 2;
    logic [31:0] slaveData = '0;
    bit lateAck;
    logic [31:0] lastRdata, riseWData;
    logic [1:0] lastRresp, lastBresp;
    logic [7:0] riseAddr;
    logic riseWe;
    int cyc = 0;
    int arHsCyc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mapAddr(input logic [15:0] a);
        return {a[7:2], 2'b00};
    endfunction

    task automatic checkReq();
        chk("regWriteEn", regWriteEn, curWrite);
        chk("regAddr", regAddr, mapAddr(curWrite ? mAwAddr : mArAddr));
        if (curWrite) begin
            chk("regWData", regWData, mWData);
            chk("regWStrb", regWStrb, mWStrb);
        end
    endtask

    always @(negedge clk) begin
        bit eW, eR;
        if (srst) begin
            awPend = 0; wPend = 0; arPend = 0;
            prevEligW = 0; prevEligR = 0; tieRead = 1;
            inTxn = 0; regAck = 0; lowRun = 0;
            expB.delete(); expR.delete();
        end else begin
            regAck = 0;
            eW = awPend && wPend;
            eR = arPend;
            chk("awready", s_awready, !awPend);
            chk("wready", s_wready, !wPend);
            chk("arready", s_arready, !arPend);
            if (inTxn && (ackGiven || timedOut)) begin
                chk("reqDrop", regReq, 0);
                chk(curWrite ? "bvalidDue" : "rvalidDue",
                    curWrite ? s_bvalid : s_rvalid, 1);
                inTxn = 0;
                reqLen = reqCycles;
            end else if (inTxn) begin
                chk("reqHeld", regReq, 1);
                checkReq();
            end else if (regReq) begin
                if (prevEligW || prevEligR) begin
                    if (prevEligW && prevEligR) begin
                        curWrite = !tieRead;
                        tieRead = !tieRead;
                    end else begin
                        curWrite = prevEligW;
                    end
                    inTxn = 1; reqCycles = 0;
                    ackGiven = 0; timedOut = 0;
                    served.push_back(curWrite);
                    reqRiseCyc = cyc; lastGap = lowRun;
                    riseAddr = regAddr; riseWe = regWriteEn;
                    riseWData = regWData;
                    checkReq();
                end else begin
                    chk("spuriousReq", regReq, 0);
                end
            end
            if (regReq) lowRun = 0;
            else lowRun++;
            if (inTxn) begin
                reqCycles++;
                if (reqCycles == ackDelay + 1) begin
                    regAck = 1;
                    regRData = slaveData;
                    ackGiven = 1;
                    if (curWrite) expB.push_back('{resp: 2'b00, data: 32'h0});
                    else expR.push_back('{resp: 2'b00, data: slaveData});
                end
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
                else if (reqCycles == TO) begin
                    timedOut = 1;
                    if (curWrite) expB.push_back('{resp: 2'b10, data: 32'h0});
                    else expR.push_back('{resp: 2'b10, data: 32'h0});
                end
`endif
            end else if (lateAck) begin
                regAck = 1;
                regRData = 32'hBAD0_0BAD;
                lateAck = 0;
            end
            if (s_bvalid) begin
                if (expB.size() == 0) begin
                    chk("unexpectedB", s_bvalid, 0);
                end else begin
                    chk("bresp", s_bresp, expB[0].resp);
                    lastBresp = s_bresp;
                    if (s_bready) begin
                        void'(expB.pop_front());
                        awPend = 0; wPend = 0;
                    end
                end
            end
            if (s_rvalid) begin
                if (expR.size() == 0) begin
                    chk("unexpectedR", s_rvalid, 0);
                end else begin
                    chk("rresp", s_rresp, expR[0].resp);
                    chk("rdata", s_rdata, expR[0].data);
                    lastRresp = s_rresp;
                    lastRdata = s_rdata;
                    if (s_rready) begin
                        void'(expR.pop_front());
                        arPend = 0;
                    end
                end
            end
            if (s_awvalid && s_awready) begin
                awPend = 1; mAwAddr = s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                wPend = 1; mWData = s_wdata; mWStrb = s_wstrb;
            end
            if (s_arvalid && s_arready) begin
                arPend = 1; mArAddr = s_araddr;
            end
            prevEligW = eW;
            prevEligR = eR;
        end
    end

    task automatic send(input bit aw, input bit w, input bit ar,
                        input logic [15:0] awA, input logic [31:0] wD,
                        input logic [3:0] wS, input logic [15:0] arA);
        bit dAw, dW, dAr;
        @(posedge clk); #1;
        s_awvalid = aw; s_awaddr = awA;
        s_wvalid = w; s_wdata = wD; s_wstrb = wS;
        s_arvalid = ar; s_araddr = arA;
        for (int i = 0; i < 200; i++) begin
            if (!(s_awvalid || s_wvalid || s_arvalid)) break;
            @(negedge clk);
            dAw = s_awvalid && s_awready;
            dW = s_wvalid && s_wready;
            dAr = s_arvalid && s_arready;
            @(posedge clk); #1;
            if (dAw) s_awvalid = 0;
            if (dW) s_wvalid = 0;
            if (dAr) begin
                s_arvalid = 0;
                arHsCyc = cyc;
            end
        end
        if (s_awvalid || s_wvalid || s_arvalid) begin
            chk("acceptTimeout", 0, 1);
            s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!inTxn && !awPend && !wPend && !arPend &&
                expB.size() == 0 && expR.size() == 0) return;
        end
        chk("idleTimeout", 0, 1);
    endtask

    task automatic waitRvalid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (s_rvalid) return;
        end
        chk("rvalidTimeout", 0, 1);
    endtask

    task automatic doReset();
        @(posedge clk); #1 srst = 1;
        @(posedge clk); #1 srst = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 srst = 0;
        @(negedge clk);
        chk("rstRegReq", regReq, 0);
        chk("rstBvalid", s_bvalid, 0);
        chk("rstRvalid", s_rvalid, 0);
        chk("rstAwready", s_awready, 1);
        chk("rstWready", s_wready, 1);
        chk("rstArready", s_arready, 1);
        chk("rstRdata", s_rdata, 0);
        chk("rstBresp", s_bresp, 0);
        chk("rstRresp", s_rresp, 0);
        chk("rstRegAddr", regAddr, 0);
        chk("rstRegWData", regWData, 0);

        // Test 1: single write, ack two cycles after regReq
        ackDelay = 2;
        send(1, 1, 0, 16'h0000, 32'h0000_0001, 4'hF, 16'h0);
        waitIdle();
        chk("t1Kind", served[served.size()-1], 1);
        chk("t1We", riseWe, 1);
        chk("t1Addr", riseAddr, 8'h00);
        chk("t1WData", riseWData, 32'h1);
        chk("t1Bresp", lastBresp, 2'b00);

        // Test 2: read with latency and rready backpressure
        slaveData = 32'h0000_0001;
        s_rready = 0;
        send(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0004);
        waitRvalid();
        chk("t2RvalidLat", cyc - arHsCyc, 4);
        chk("t2ReqLat", reqRiseCyc - arHsCyc, 1);
        chk("t2Addr", riseAddr, 8'h04);
        repeat (2) begin
            @(negedge clk);
            chk("t2RvalidHold", s_rvalid, 1);
        end
        @(posedge clk); #1 s_rready = 1;
        @(negedge clk);
        chk("t2Rdata", s_rdata, 32'h1);
        waitIdle();
        chk("t2Rresp", lastRresp, 2'b00);

        // Test 3: contention, read first after reset then alternate
        doReset();
        n0 = served.size();
        slaveData = 32'h1234_5678;
        send(1, 1, 1, 16'h0010, 32'hA5A5_0001, 4'hF, 16'h0014);
        waitIdle();
        send(1, 1, 1, 16'hAB18, 32'h0000_0002, 4'h3, 16'h011F);
        waitIdle();
        chk("t3Count", served.size() - n0, 4);
        if (served.size() - n0 == 4) begin
            chk("t3First", served[n0], 0);
            chk("t3Second", served[n0+1], 1);
            chk("t3Third", served[n0+2], 1);
            chk("t3Fourth", served[n0+3], 0);
        end
        chk("t3LastAddr", riseAddr, 8'h1C);
        chk("t3Gap", lastGap >= 1, 1);

        // Test 4: W arrives five cycles ahead of AW
        send(0, 1, 0, 16'h0, 32'hDEAD_BEEF, 4'h5, 16'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4WreadyLow", s_wready, 0);
        chk("t4NoReq", regReq, 0);
        send(1, 0, 0, 16'h0020, 32'h0, 4'h0, 16'h0);
        waitIdle();
        chk("t4We", riseWe, 1);
        chk("t4Addr", riseAddr, 8'h20);
        chk("t4WData", riseWData, 32'hDEAD_BEEF);

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
        // Test 5: slave never acks, timeout gives SLVERR
        ackDelay = 1000;
        send(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h000C);
        waitRvalid();
        chk("t5Rresp", s_rresp, 2'b10);
        chk("t5Rdata", s_rdata, 32'h0);
        chk("t5ReqLen", reqLen, 16);
        waitIdle();
        lateAck = 1;
        repeat (6) @(negedge clk);
        chk("t5LateReq", regReq, 0);
        chk("t5LateRvalid", s_rvalid, 0);
        chk("t5LateBvalid", s_bvalid, 0);
`else
        // Test 5: without a timeout the bridge waits for a slow ack
        ackDelay = 40;
        slaveData = 32'h0000_C0DE;
        send(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h000C);
        waitRvalid();
        chk("t5Rresp", s_rresp, 2'b00);
        chk("t5Rdata", s_rdata, 32'h0000_C0DE);
        chk("t5ReqLen", reqLen, 41);
        waitIdle();
`endif

        // Test 6: reset while a read request is outstanding
        ackDelay = 1000;
        send(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0008);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (regReq) break;
        end
        chk("t6InReq", regReq, 1);
        @(posedge clk); #1 srst = 1;
        @(posedge clk); #1 srst = 0;
        @(negedge clk);
        chk("t6RegReq", regReq, 0);
        chk("t6Rvalid", s_rvalid, 0);
        chk("t6Bvalid", s_bvalid, 0);
        chk("t6Arready", s_arready, 1);
        ackDelay = 2;
        slaveData = 32'h600D_0006;
        send(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0008);
        waitIdle();
        chk("t6Rdata", lastRdata, 32'h600D_0006);
        chk("t6Rresp", lastRresp, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule
